// File: rtl/in_port_pkg.sv
// Shared types and default sizing for the handshaked CPU input port.
package in_port_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } in_port_state_t;

    localparam int unsigned IN_PORT_DEPTH = 4;
    localparam int unsigned IN_PORT_WIDTH = 32;

endpackage

// File: rtl/in_port_fifo.sv
// Small FIFO behind the input port: storage, wrapping pointers, occupancy
// count, registered read data and status flags.
module in_port_fifo
    import in_port_pkg::*;
#(
    parameter int unsigned DEPTH = IN_PORT_DEPTH,
    parameter int unsigned WIDTH = IN_PORT_WIDTH
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         Q,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     data_avail
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             push, pop;

    // Full/empty come from the count; a same-cycle write is never visible to a pop.
    always_comb begin
        push     = wr_en && (count_q != CW'(DEPTH));
        pop      = rd_en && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_d      = q_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            q_d      = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign Q          = q_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign data_avail = (count_q != '0);

endmodule

// File: rtl/in_port_hs.sv
// Receive-side input port: strobe synchronizer and four-phase handshake FSM
// feeding a small FIFO that the CPU drains onto the internal bus.
module in_port_hs
    import in_port_pkg::*;
#(
    parameter int unsigned DEPTH = IN_PORT_DEPTH,
    parameter int unsigned WIDTH = IN_PORT_WIDTH
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_stb,
    output logic                     in_ack,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         Q,
    output logic                     data_avail,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    in_port_state_t state_q, state_d;
    logic           stb_s1_q, stb_s2_q;
    logic           ack_q, ack_d;
    logic           wr_en;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stb_s1_q <= 1'b0;
            stb_s2_q <= 1'b0;
            state_q  <= IDLE;
            ack_q    <= 1'b0;
        end else begin
            stb_s1_q <= in_stb;
            stb_s2_q <= stb_s1_q;
            state_q  <= state_d;
            ack_q    <= ack_d;
        end
    end

    // A strobe seen while full is held off in IDLE until space frees up.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb_s2_q && !full) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!stb_s2_q) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ack = ack_q;

    in_port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk        (clk),
        .clr_n      (clr_n),
        .wr_en      (wr_en),
        .wr_data    (in_data),
        .rd_en      (rd_en),
        .Q          (Q),
        .count      (count),
        .full       (full),
        .data_avail (data_avail)
    );

endmodule

// File: tb/tb_in_port_hs.sv
// Bench for in_port_hs: directed handshake scenarios followed by a random
// mix of pushes, pops and idle cycles, compared against a queue model.
module tb_in_port_hs;
    import in_port_pkg::*;

    localparam int unsigned DEPTH = IN_PORT_DEPTH;
    localparam int unsigned WIDTH = IN_PORT_WIDTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             clr_n;
    logic [WIDTH-1:0] in_data;
    logic             in_stb;
    logic             in_ack;
    logic             rd_en;
    logic [WIDTH-1:0] Q;
    logic             data_avail;
    logic             full;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q;

    always #5 clk = ~clk;

    in_port_hs #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_data    (in_data),
        .in_stb     (in_stb),
        .in_ack     (in_ack),
        .rd_en      (rd_en),
        .Q          (Q),
        .data_avail (data_avail),
        .full       (full),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, WIDTH'(count), WIDTH'(model_q.size()));
        chk({tag, ".avail"}, WIDTH'(data_avail), WIDTH'(model_q.size() != 0));
        chk({tag, ".full"}, WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
    endtask

    // Count edges until in_ack reaches the given level (bounded).
    task automatic wait_ack(input string tag, input logic level, input int exp_edges);
        int n;
        n = 0;
        while (in_ack !== level && n < 40) begin
            tick();
            n++;
        end
        chk(tag, WIDTH'(n), WIDTH'(exp_edges));
    endtask

    task automatic raise(input logic [WIDTH-1:0] d);
        in_data = d;
        in_stb  = 1'b1;
    endtask

    task automatic release_stb(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_ack"}, WIDTH'(in_ack), WIDTH'(1));
            check_status({tag, ".hold"});
        end
        in_stb = 1'b0;
        wait_ack({tag, ".ack_fall"}, 1'b0, 3);
    endtask

    task automatic push(input string tag, input logic [WIDTH-1:0] d, input int hold);
        raise(d);
        wait_ack({tag, ".ack_rise"}, 1'b1, 3);
        model_q.push_back(d);
        check_status(tag);
        release_stb(tag, hold);
    endtask

    task automatic pop(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (model_q.size() != 0) exp_q = model_q.pop_front();
        chk({tag, ".Q"}, Q, exp_q);
        check_status(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n   = 1'b0;
        in_stb  = 1'b0;
        in_data = '0;
        rd_en   = 1'b0;
        exp_q   = '0;
        repeat (3) tick();
        chk("reset.Q", Q, '0);
        chk("reset.ack", WIDTH'(in_ack), WIDTH'(0));
        check_status("reset");
        clr_n = 1'b1;
        tick();

        // single transfer
        push("single", 32'h0000_00A5, 0);
        pop("single.pop");

        // asynchronous reset mid-ACK, strobe kept high through reset
        raise(32'h0000_0077);
        wait_ack("rst.pre_ack", 1'b1, 3);
        clr_n = 1'b0;
        #1;
        model_q.delete();
        exp_q = '0;
        chk("rst.async_ack", WIDTH'(in_ack), WIDTH'(0));
        chk("rst.async_Q", Q, '0);
        check_status("rst.async");
        @(negedge clk);
        tick();
        clr_n = 1'b1;
        wait_ack("rst.rerequest", 1'b1, 3);
        model_q.push_back(32'h0000_0077);
        check_status("rst.rerequest");
        release_stb("rst", 1);
        pop("rst.pop");

        // fill and backpressure
        push("fill1", 32'h11, 0);
        push("fill2", 32'h22, 0);
        push("fill3", 32'h33, 0);
        push("fill4", 32'h44, 0);
        raise(32'h55);
        repeat (6) tick();
        chk("bp.no_ack", WIDTH'(in_ack), WIDTH'(0));
        check_status("bp.held");
        pop("bp.pop");
        chk("bp.pop_Q11", Q, 32'h11);
        wait_ack("bp.ack_after_pop", 1'b1, 1);
        model_q.push_back(32'h55);
        check_status("bp.captured");
        release_stb("bp", 2);

        // drain, then read while empty
        while (model_q.size() != 0) pop("drain");
        pop("empty.pop");
        chk("empty.Q_kept", Q, 32'h55);

        // wrap-around
        for (int i = 1; i <= 10; i++) begin
            push("wrap.push", WIDTH'(i), 0);
            pop("wrap.pop");
        end
        chk("wrap.last", Q, 32'hA);

        // simultaneous capture and pop
        push("sim1", 32'hB1, 0);
        push("sim2", 32'hB2, 0);
        raise(32'hB3);
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        exp_q = model_q.pop_front();
        model_q.push_back(32'hB3);
        chk("sim.ack", WIDTH'(in_ack), WIDTH'(1));
        chk("sim.Q", Q, 32'hB1);
        check_status("sim");
        release_stb("sim", 0);

        // random mix
        for (int it = 0; it < 60; it++) begin
            int unsigned op;
            logic [WIDTH-1:0] d;
            op = $urandom_range(0, 3);
            d  = $urandom;
            if (op <= 1) begin
                if (model_q.size() < DEPTH) begin
                    push("rnd.push", d, int'($urandom_range(0, 3)));
                end else begin
                    raise(d);
                    repeat ($urandom_range(2, 5)) tick();
                    chk("rnd.bp_no_ack", WIDTH'(in_ack), WIDTH'(0));
                    pop("rnd.bp_pop");
                    wait_ack("rnd.bp_ack", 1'b1, 1);
                    model_q.push_back(d);
                    check_status("rnd.bp");
                    release_stb("rnd.bp", 0);
                end
            end else if (op == 2) begin
                pop("rnd.pop");
            end else begin
                repeat ($urandom_range(1, 3)) tick();
                chk("rnd.idle_Q", Q, exp_q);
                check_status("rnd.idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
